// File: rtl/br_pkg.sv
// Shared definitions for the branch resolution controller: funct3 codes,
// FSM encoding, BHT reset value and the saturating-counter update rule.
package br_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_RESP  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Weakly not-taken.
  localparam logic [1:0] BHT_RESET = 2'b01;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11)
      nxt = ctr + 2'b01;
    else if (!taken && ctr != 2'b00)
      nxt = ctr - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2^BHT_IDX two-bit saturating counters with one
// combinational read port and one update port.
module branch_bht
  import br_pkg::*;
#(
  parameter int BHT_IDX = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [BHT_IDX-1:0] rd_idx,
  output logic               rd_taken,
  input  logic [BHT_IDX-1:0] wr_idx,
  input  logic               wr_taken,
  input  logic               we
);

  localparam int ENTRIES = 1 << BHT_IDX;

  logic [1:0] ctr [ENTRIES];

  // NOTE: the table is small and its reset value is architecturally visible
  // (predictions right after reset), so every entry gets the reset, not just control.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++)
        ctr[i] <= BHT_RESET;
    end else if (we) begin
      ctr[wr_idx] <= sat_update(ctr[wr_idx], wr_taken);
    end
  end

  // Reads see the pre-update value when read and write hit the same entry.
  assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: evaluates one branch at a time, checks the
// prediction, redirects/flushes on mispredict, trains the BHT.
// Optional perf counters enabled by defining BR_PERF_CNT_EN.
module branch_resolve_ctrl
  import br_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BHT_IDX      = 6,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] Rs1,
  input  logic [XLEN-1:0] Rs2,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic            resolve_valid,
  output logic            resolve_taken,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            illegal_br
`ifdef BR_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES) + 1;

  state_t state, state_next;

  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  rs1_q, rs2_q, pc_q, imm_q;
  logic             pred_q;
  logic             mis_q;
  logic [CNT_W-1:0] flush_cnt;

  logic             accept;
  logic             eval_taken, eval_illegal, eval_mis;
  logic [XLEN-1:0]  target, fallthrough;

  logic             br_ready_d, resolve_valid_d, resolve_taken_d;
  logic             redirect_valid_d, flush_d, illegal_d;
  logic [XLEN-1:0]  redirect_pc_d;

  logic             lookup_unused;

  assign accept = br_valid & br_ready;

  // Operand capture; no reset needed since nothing reads these before an accept.
  always_ff @(posedge CLK) begin
    if (accept) begin
      funct3_q <= funct3;
      rs1_q    <= Rs1;
      rs2_q    <= Rs2;
      pc_q     <= br_pc;
      imm_q    <= br_imm;
      pred_q   <= pred_taken;
    end
  end

  always_comb begin
    eval_taken   = 1'b0;
    eval_illegal = 1'b0;
    case (funct3_q)
      BEQ:     eval_taken = (rs1_q == rs2_q);
      BNE:     eval_taken = (rs1_q != rs2_q);
      BLT:     eval_taken = ($signed(rs1_q) <  $signed(rs2_q));
      BGE:     eval_taken = ($signed(rs1_q) >= $signed(rs2_q));
      BLTU:    eval_taken = (rs1_q <  rs2_q);
      BGEU:    eval_taken = (rs1_q >= rs2_q);
      default: eval_illegal = 1'b1;
    endcase
  end

  assign eval_mis    = eval_taken ^ pred_q;
  assign target      = pc_q + imm_q;
  assign fallthrough = pc_q + XLEN'(4);

  // State register plus the bookkeeping the next-state logic depends on.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      mis_q     <= 1'b0;
      flush_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_EVAL)
        mis_q <= eval_mis;
      if (state == ST_RESP)
        flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
      else if (state == ST_FLUSH)
        flush_cnt <= flush_cnt - 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_EVAL;
      ST_EVAL:  state_next = ST_RESP;
      ST_RESP:  state_next = (mis_q && FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
      ST_FLUSH: if (flush_cnt <= CNT_W'(1)) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs are computed one cycle early and registered, so RESP-cycle pulses
  // are loaded at the end of EVAL.
  always_comb begin
    br_ready_d       = (state_next == ST_IDLE);
    resolve_valid_d  = (state == ST_EVAL);
    resolve_taken_d  = (state == ST_EVAL) && eval_taken;
    illegal_d        = (state == ST_EVAL) && eval_illegal;
    redirect_valid_d = (state == ST_EVAL) && eval_mis;
    redirect_pc_d    = '0;
    if (state == ST_EVAL && eval_mis)
      redirect_pc_d = eval_taken ? target : fallthrough;
    flush_d          = redirect_valid_d || (state_next == ST_FLUSH);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      br_ready       <= 1'b1;
      resolve_valid  <= 1'b0;
      resolve_taken  <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      illegal_br     <= 1'b0;
    end else begin
      br_ready       <= br_ready_d;
      resolve_valid  <= resolve_valid_d;
      resolve_taken  <= resolve_taken_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
      flush          <= flush_d;
      illegal_br     <= illegal_d;
    end
  end

  branch_bht #(.BHT_IDX(BHT_IDX)) u_bht (
    .CLK      (CLK),
    .RST      (RST),
    .rd_idx   (lookup_pc[BHT_IDX+1:2]),
    .rd_taken (lookup_taken),
    .wr_idx   (pc_q[BHT_IDX+1:2]),
    .wr_taken (eval_taken),
    .we       ((state == ST_EVAL) && !eval_illegal)
  );

  // Only the index bits of the fetch PC select a BHT entry.
  assign lookup_unused = &{1'b0, lookup_pc[XLEN-1:BHT_IDX+2], lookup_pc[1:0]};

`ifdef BR_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (resolve_valid)
        perf_branches <= perf_branches + 32'd1;
      if (redirect_valid)
        perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl (default FLUSH_CYCLES=2).
module tb_branch_resolve_ctrl;
  import br_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  funct3;
  logic [31:0] Rs1, Rs2, br_pc, br_imm;
  logic        pred_taken;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
  logic        resolve_valid, resolve_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        illegal_br;
`ifdef BR_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  int total  = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  branch_resolve_ctrl #(.XLEN(32), .BHT_IDX(6), .FLUSH_CYCLES(2)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .funct3         (funct3),
    .Rs1            (Rs1),
    .Rs2            (Rs2),
    .br_pc          (br_pc),
    .br_imm         (br_imm),
    .pred_taken     (pred_taken),
    .lookup_pc      (lookup_pc),
    .lookup_taken   (lookup_taken),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .illegal_br     (illegal_br)
`ifdef BR_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
    lookup_pc = pc;
    #1;
    check(tag, {31'd0, lookup_taken}, {31'd0, exp});
  endtask

  // Waits (bounded) for br_ready at a negedge, presents the branch, returns
  // just after the accepting edge (cycle T).
  task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                       input logic pred);
    int n = 0;
    while (br_ready !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) check({tag, "_ready_timeout"}, {31'd0, br_ready}, 32'd1);
    funct3 = f3; Rs1 = a; Rs2 = b; br_pc = pc; br_imm = imm; pred_taken = pred;
    br_valid = 1'b1;
    @(posedge CLK);
    #1 br_valid = 1'b0;
  endtask

  // Full transaction with cycle-accurate checks of the response and flush window.
  task automatic run_branch(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                            input logic pred, input logic exp_taken, input logic exp_ill,
                            input logic [31:0] exp_rpc, input logic chk_lk, input logic exp_lk);
    logic exp_mis;
    exp_mis = exp_taken ^ pred;
    issue(tag, f3, a, b, pc, imm, pred);
    @(negedge CLK);  // T+1, EVAL
    check({tag, "_t1_resolve"}, {31'd0, resolve_valid}, 32'd0);
    check({tag, "_t1_ready"}, {31'd0, br_ready}, 32'd0);
    if (chk_lk) check({tag, "_t1_lookup_pre"}, {31'd0, lookup_taken}, {31'd0, exp_lk});
    @(negedge CLK);  // T+2, RESP
    check({tag, "_resolve_valid"}, {31'd0, resolve_valid}, 32'd1);
    check({tag, "_resolve_taken"}, {31'd0, resolve_taken}, {31'd0, exp_taken});
    check({tag, "_illegal"}, {31'd0, illegal_br}, {31'd0, exp_ill});
    check({tag, "_redirect_valid"}, {31'd0, redirect_valid}, {31'd0, exp_mis});
    check({tag, "_flush"}, {31'd0, flush}, {31'd0, exp_mis});
    if (exp_mis) check({tag, "_redirect_pc"}, redirect_pc, exp_rpc);
    @(negedge CLK);  // T+3
    check({tag, "_t3_resolve"}, {31'd0, resolve_valid}, 32'd0);
    check({tag, "_t3_redirect"}, {31'd0, redirect_valid}, 32'd0);
    check({tag, "_t3_flush"}, {31'd0, flush}, {31'd0, exp_mis});
    check({tag, "_t3_ready"}, {31'd0, br_ready}, {31'd0, !exp_mis});
    if (exp_mis) begin
      @(negedge CLK);  // T+4
      check({tag, "_t4_flush"}, {31'd0, flush}, 32'd0);
      check({tag, "_t4_ready"}, {31'd0, br_ready}, 32'd1);
    end
  endtask

  initial begin
    RST = 1'b1; br_valid = 1'b0; funct3 = 3'b000; Rs1 = '0; Rs2 = '0;
    br_pc = '0; br_imm = '0; pred_taken = 1'b0; lookup_pc = 32'h40;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    check("rst_ready", {31'd0, br_ready}, 32'd1);
    check("rst_resolve", {31'd0, resolve_valid}, 32'd0);
    check("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_illegal", {31'd0, illegal_br}, 32'd0);
    lookup("rst_lookup_40", 32'h40, 1'b0);

    // Correct prediction, BHT idx0 01->10.
    run_branch("beq_ok", BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    lookup("beq_ok_lookup", 32'h100, 1'b1);

    // Signed vs unsigned with -7 and 4.
    run_branch("blt", BLT, 32'hFFFF_FFF9, 32'd4, 32'h304, 32'h40, 1'b0, 1'b1, 1'b0, 32'h344, 1'b0, 1'b0);
    run_branch("bltu", BLTU, 32'hFFFF_FFF9, 32'd4, 32'h308, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    run_branch("bge", BGE, 32'hFFFF_FFF9, 32'd4, 32'h50C, 32'h40, 1'b1, 1'b0, 1'b0, 32'h510, 1'b0, 1'b0);

    // Mispredict to fallthrough; idx0 10->01.
    run_branch("bgeu", BGEU, 32'd4, 32'hFFFF_FFF6, 32'h200, 32'h20, 1'b1, 1'b0, 1'b0, 32'h204, 1'b0, 1'b0);
    lookup("bgeu_lookup_idx0", 32'h100, 1'b0);

    // Target wraps modulo 2^32.
    run_branch("bne_wrap", BNE, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20, 1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0);
    lookup("bne_wrap_lookup", 32'hFFFF_FFF0, 1'b1);

    // Saturation at 0x40; first update checks same-cycle read returns old value.
    lookup_pc = 32'h40;
    run_branch("sat1", BEQ, 32'd3, 32'd3, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    lookup("sat1_lookup", 32'h40, 1'b1);
    run_branch("sat2", BEQ, 32'd3, 32'd3, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    run_branch("sat3", BEQ, 32'd3, 32'd3, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    run_branch("sat4", BEQ, 32'd3, 32'd3, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    lookup("sat4_lookup", 32'h40, 1'b1);
    run_branch("nt1", BEQ, 32'd1, 32'd2, 32'h40, 32'h80, 1'b1, 1'b0, 1'b0, 32'h44, 1'b0, 1'b0);
    lookup("nt1_lookup", 32'h40, 1'b1);

    // Illegal with pred=1 redirects to fallthrough and leaves the BHT at 10.
    run_branch("ill010", 3'b010, 32'd3, 32'd3, 32'h40, 32'h80, 1'b1, 1'b0, 1'b1, 32'h44, 1'b0, 1'b0);
    lookup("ill010_lookup", 32'h40, 1'b1);
    run_branch("nt2", BEQ, 32'd1, 32'd2, 32'h40, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    lookup("nt2_lookup", 32'h40, 1'b0);
    run_branch("ill011", 3'b011, 32'd3, 32'd3, 32'h40, 32'h80, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

    // Reset during EVAL aborts the branch: no resolve pulse, BHT back to 01.
    issue("rst_eval", BEQ, 32'd5, 32'd5, 32'h40, 32'h80, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rst_eval_resolve", {31'd0, resolve_valid}, 32'd0);
    check("rst_eval_redirect", {31'd0, redirect_valid}, 32'd0);
    check("rst_eval_ready", {31'd0, br_ready}, 32'd1);
    lookup("rst_eval_lookup", 32'hFFFF_FFF0, 1'b0);

    // Reset during FLUSH drops flush the next cycle.
    issue("rst_flush", BNE, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20, 1'b0);
    repeat (3) @(negedge CLK);
    check("rst_flush_pre", {31'd0, flush}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rst_flush_flush", {31'd0, flush}, 32'd0);
    check("rst_flush_ready", {31'd0, br_ready}, 32'd1);
    lookup("rst_flush_lookup", 32'hFFFF_FFF0, 1'b0);
`ifdef BR_PERF_CNT_EN
    check("rst_perf_br", perf_branches, 32'd0);
    check("rst_perf_mis", perf_mispredicts, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences branch resolution for the integer pipeline. Accepts one conditional branch at a time from issue over a valid/ready handshake, evaluates the condition on registered operands, and checks the result against the front-end prediction.
- On a mispredict it issues a PC redirect and a multi-cycle flush.
- Owns the 2-bit saturating branch history table (BHT) that the fetch stage queries for predictions.

Parameters:
- XLEN, 32, operand/PC width
- BHT_IDX, 6, log2 of BHT entries (64)
- FLUSH_CYCLES, 2, cycles flush held on mispredict (>=1)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- br_valid  in  1  branch offered by issue
- br_ready  out  1  controller can accept
- funct3  in  3  branch type
- Rs1  in  XLEN  source operand 1
- Rs2  in  XLEN  source operand 2
- br_pc  in  XLEN  branch PC
- br_imm  in  XLEN  sign-extended offset
- pred_taken  in  1  prediction used by fetch for this branch
- lookup_pc  in  XLEN  fetch PC for prediction
- lookup_taken  out  1  BHT prediction (combinational)
- resolve_valid  out  1  one-cycle resolution pulse
- resolve_taken  out  1  actual outcome
- redirect_valid  out  1  PC redirect pulse
- redirect_pc  out  XLEN  corrected PC
- flush  out  1  squash younger instructions
- illegal_br  out  1  funct3 was 010/011

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-high, RST.
- Reset: state IDLE; br_ready=1; all other outputs 0; every BHT entry = 2'b01 (weakly not-taken). RST mid-operation aborts any branch in flight: no resolve or redirect pulse, flush drops next cycle.
- FSM states: IDLE, EVAL, RESP, FLUSH. All outputs are registered except lookup_taken.
- IDLE:
  - br_ready=1.
  - On br_valid&br_ready, latch funct3, Rs1, Rs2, br_pc, br_imm, pred_taken; go to EVAL.
- EVAL (1 cycle): compute taken from the latched operands.
  - BEQ 000: ==
  - BNE 001: !=
  - BLT 100: signed <
  - BGE 101: signed >=
  - BLTU 110: unsigned <
  - BGEU 111: unsigned >=
  - 010/011: taken=0, illegal_br=1.
  - Compute target = br_pc+br_imm and fallthrough = br_pc+4, both mod 2^XLEN (wrap, no overflow flag).
  - mispredict = taken ^ pred_taken.
  - Update the BHT entry at br_pc[BHT_IDX+1:2]: taken -> increment saturating at 11; not-taken -> decrement saturating at 00.
  - Illegal branches do not update the BHT.
  - Go to RESP.
- RESP (1 cycle):
  - resolve_valid=1, resolve_taken=taken.
  - If mispredict: redirect_valid=1, redirect_pc = taken ? target : fallthrough, flush=1.
  - Next state: mispredict and FLUSH_CYCLES>1 -> FLUSH; else IDLE.
  - An illegal branch with pred_taken=1 counts as a mispredict and redirects to fallthrough.
- FLUSH: flush=1 for FLUSH_CYCLES-1 more cycles, tracked by a down-counter; then IDLE.
- Latency: accept at cycle T -> resolve_valid at T+2; br_ready=1 again at T+3 when correct, at T+2+FLUSH_CYCLES when mispredicted.
- lookup_taken = MSB of BHT[lookup_pc[BHT_IDX+1:2]]. A lookup and an update to the same index in the same cycle return the pre-update value.
- br_valid is ignored outside IDLE; issue must hold its operands until accepted.

Optional Feature:
- Macro: BR_PERF_CNT_EN.
- Defined: adds outputs perf_branches and perf_mispredicts, 32 bits each.
  - perf_branches increments on every resolve_valid.
  - perf_mispredicts increments on every redirect_valid.
  - Both wrap at 2^32 and clear on RST.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package br_pkg holds:
  - funct3 localparams BEQ/BNE/BLT/BGE/BLTU/BGEU
  - FSM state encoding
  - BHT reset value 2'b01
- Sub-module branch_bht: 2^BHT_IDX x 2-bit counter array with one combinational read port, one update port (index, taken, we), and synchronous reset.

Test Plan:
- Correct prediction: BEQ Rs1=5 Rs2=5 pred_taken=1 br_pc=0x100 br_imm=0x20 -> resolve_valid at T+2, resolve_taken=1, no redirect, br_ready back at T+3.
- Signed vs unsigned: BLT Rs1=-7 Rs2=4 pred=0 -> redirect_pc=target, flush high 2 cycles. BLTU with the same operands, pred=0 -> not taken, no redirect.
- Mispredict to fallthrough: BGEU Rs1=4 Rs2=0xFFFFFFF6 pred=1 br_pc=0x200 -> redirect_pc=0x204, flush 2 cycles.
- Wrap: BNE Rs1=1 Rs2=2 br_pc=0xFFFFFFF0 br_imm=0x20, pred=0 -> redirect_pc=0x00000010.
- BHT saturation: 4 taken BEQ at PC 0x40 -> lookup_taken for 0x40 becomes 1 after the 1st, counter saturates at 11. Then 1 not-taken -> lookup_taken stays 1. funct3=010 -> illegal_br=1, BHT unchanged.
- Reset mid-flush: assert RST during FLUSH -> next cycle flush=0, br_ready=1, BHT at 01; with BR_PERF_CNT_EN, counters read 0.
